// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan driver: digit count, active-low {a..g}
// segment patterns, decimal-point positions and the BLANK/DRIVE state type.
package fnd_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;

    // Decimal points sit after the seconds-units and minutes-units digits.
    localparam logic [2:0] DP_IDX_LO = 3'd2;
    localparam logic [2:0] DP_IDX_HI = 3'd4;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment {a..g} decoder; codes 10-15
// render as a dash.
module bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Six-digit common-anode FND scan driver with frame snapshot and BLANK/DRIVE
// anti-ghosting. Optional leading-zero blanking via FND_LZ_BLANK_EN.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned SCAN_HZ   = 1000,
    parameter int unsigned BLANK_CYC = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] t_ms0,
    input  logic [3:0] t_ms1,
    input  logic [3:0] t_s0,
    input  logic [3:0] t_s1,
    input  logic [3:0] t_m0,
    input  logic [3:0] t_m1,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [5:0] o_com
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(BLANK_CYC) + 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [BW-1:0] BLK_MAX  = BW'(BLANK_CYC - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]                presc_q, presc_d;
    logic [2:0]                   idx_q, idx_d;
    logic [BW-1:0]                blank_q, blank_d;
    state_t                       state_q, state_d;
    logic                         armed_q, armed_d;
    logic [NUM_DIGITS-1:0][3:0]   snap_q, snap_d;
    logic                         tick;
    logic [3:0]                   digit;
    logic [6:0]                   seg_dec, seg_d;
    logic [5:0]                   com_d;
    logic                         dp_d;

    bcd_to_seg u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    always_comb begin
        tick    = (presc_q == PRE_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        snap_d  = snap_q;
        armed_d = armed_q;
        state_d = state_q;
        blank_d = blank_q;

        if (tick) begin
            state_d = ST_BLANK;
            blank_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                snap_d  = {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0};
                armed_d = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else if (state_q == ST_BLANK) begin
            // Stay dark until the first snapshot exists, so the all-zero
            // reset snapshot is never shown on idx5.
            if (armed_q && blank_q == BLK_MAX) begin
                state_d = ST_DRIVE;
                blank_d = '0;
            end else begin
                blank_d = blank_q + 1'b1;
            end
        end

        // Outputs are computed from next-state values so the registered
        // outputs line up with the state register.
        digit = snap_d[idx_d];
        com_d = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == ST_DRIVE) begin
            com_d = ~(6'b000001 << idx_d);
            seg_d = seg_dec;
            dp_d  = !(idx_d == DP_IDX_LO || idx_d == DP_IDX_HI);
`ifdef FND_LZ_BLANK_EN
            if (snap_d[5] == 4'd0 && idx_d == 3'd5)
                seg_d = SEG_OFF;
            if (snap_d[5] == 4'd0 && snap_d[4] == 4'd0 && idx_d == 3'd4)
                seg_d = SEG_OFF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= IDX_LAST;
            blank_q <= '0;
            state_q <= ST_BLANK;
            armed_q <= 1'b0;
            snap_q  <= '0;
            o_com   <= '1;
            o_seg   <= SEG_OFF;
            o_dp    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
            state_q <= state_d;
            armed_q <= armed_d;
            snap_q  <= snap_d;
            o_com   <= com_d;
            o_seg   <= seg_d;
            o_dp    <= dp_d;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver (DIV=10, BLANK_CYC=2): a slot/phase
// timing model predicts every cycle's outputs; a monitor compares them.
module tb_fnd_scan_driver;

    localparam int DIVV = 10;
    localparam int BLK  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] t_ms0 = 4'd1, t_ms1 = 4'd2, t_s0 = 4'd3;
    logic [3:0] t_s1 = 4'd4, t_m0 = 4'd5, t_m1 = 4'd6;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [5:0] o_com;

    fnd_scan_driver #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (BLK)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .t_ms0 (t_ms0),
        .t_ms1 (t_ms1),
        .t_s0  (t_s0),
        .t_s1  (t_s1),
        .t_m0  (t_m0),
        .t_m1  (t_m1),
        .o_seg (o_seg),
        .o_dp  (o_dp),
        .o_com (o_com)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [5:0] com;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   n = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [3:0] frame [6];
    logic [6:0] seg_tbl [10];

    initial begin
        seg_tbl[0] = 7'b0000001; seg_tbl[1] = 7'b1001111;
        seg_tbl[2] = 7'b0010010; seg_tbl[3] = 7'b0000110;
        seg_tbl[4] = 7'b1001100; seg_tbl[5] = 7'b0100100;
        seg_tbl[6] = 7'b0100000; seg_tbl[7] = 7'b0001111;
        seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0000100;
        for (int i = 0; i < 6; i++) frame[i] = 4'd0;
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        if (v > 4'd9) return 7'b1111110;
        return seg_tbl[v];
    endfunction

    // Model: n counts edges since reset release; ticks land on multiples of
    // DIV, slot k shows digit (k-1)%6 once BLK cycles of its slot have passed.
    always @(posedge clk) begin
        exp_t e;
        int   k, ph, d;
        if (rst) n = 0;
        else     n = n + 1;
        if (!rst && (n % (6 * DIVV)) == DIVV) begin
            frame[0] = t_ms0; frame[1] = t_ms1; frame[2] = t_s0;
            frame[3] = t_s1;  frame[4] = t_m0;  frame[5] = t_m1;
        end
        k = n / DIVV;
        ph = n % DIVV;
        e.n = n;
        e.com = 6'b111111;
        e.seg = 7'b1111111;
        e.dp = 1'b1;
        if (!rst && k > 0 && ph >= BLK) begin
            d = (k - 1) % 6;
            e.com = 6'b111111;
            e.com[d] = 1'b0;
            e.seg = ref_seg(frame[d]);
            e.dp = (d == 2 || d == 4) ? 1'b0 : 1'b1;
`ifdef FND_LZ_BLANK_EN
            if (d == 5 && frame[5] == 4'd0) e.seg = 7'b1111111;
            if (d == 4 && frame[5] == 4'd0 && frame[4] == 4'd0) e.seg = 7'b1111111;
`endif
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (o_com === e.com && o_seg === e.seg && o_dp === e.dp)
                n_pass++;
            else
                $display("FAIL out n=%0d com got %b exp %b seg got %b exp %b dp got %b exp %b",
                         e.n, o_com, e.com, o_seg, e.seg, o_dp, e.dp);
        end
    end

    task automatic cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        // Two full frames of the 1..6 pattern.
        cycles(100);
        // Mid-frame change (idx3 slot of frame 2): only visible next frame.
        t_m1 = 4'd9;
        cycles(130);
        t_s1 = 4'hA;
        cycles(70);
        t_m1 = 4'd0;
        t_m0 = 4'd0;
        cycles(130);
        // Reset in the middle of an idx3 DRIVE slot.
        for (int i = 0; i < 100 && (n % 60) != 45; i++) cycles(1);
        if ((n % 60) != 45) begin
            n_checks++;
            $display("FAIL align got n=%0d exp n%%60=45", n);
        end
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(80);
        // Randomized digits, with zeros favoured, plus rare reset pulses.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [3:0] v;
                v = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                case ($urandom_range(0, 5))
                    0: t_ms0 = v;
                    1: t_ms1 = v;
                    2: t_s0  = v;
                    3: t_s1  = v;
                    4: t_m0  = v;
                    default: t_m1 = v;
                endcase
            end
            rst = ($urandom_range(0, 399) == 0);
            cycles(1);
        end
        rst = 1'b0;
        cycles(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
